// File: rtl/reg_bank_p.sv
// reg_bank_p -- register bank between the control unit and the ALU.
//
// DEPTH registers of DATA_W bits. There is one write port, fed by a five-way
// source mux. Two ALU read ports can forward same-cycle write data (BYPASS=1).
// Register 0 is always visible on a fixed output tap, and a sequencer zeroes
// the whole bank over DEPTH cycles.
//
// Ports:
//   clk                  rising-edge clock
//   res                  asynchronous active-low reset
//   in_a, in_b           external data, sources 0 and 1
//   cu_const             control-unit constant, source 2
//   alu_out              ALU result, source 3
//   src_sel              write source select (4..7 = move from mov_addr)
//   wr_en, wr_addr       write request and destination register
//   mov_addr             source register for a move
//   rd_addr_a/b          read port addresses
//   clr_req              start the clear sequence
//   alu_in_a/b           read port data
//   out                  register 0 contents (never bypassed)
//   busy                 clear sequence in progress
//   wr_drop              one-cycle pulse after a write rejected during a clear
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal operation, writes accepted, clr_req starts a clear
// CLEAR | zeroing reg[cnt] each cycle, writes rejected, clr_req ignored
module reg_bank_p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] cu_const,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        src_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] mov_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr_req,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regArr [DEPTH];
  logic [DATA_W-1:0] wd;
  logic              wrAcc;

  // A move reads the array before this cycle's update, so a self-move
  // rewrites the register with its own value.
  always_comb begin
    wd = regArr[mov_addr];
    case (src_sel)
      3'd0:    wd = in_a;
      3'd1:    wd = in_b;
      3'd2:    wd = cu_const;
      3'd3:    wd = alu_out;
      default: wd = regArr[mov_addr];
    endcase
  end

  assign wrAcc = wr_en && (state == IDLE);

  assign alu_in_a = ((BYPASS != 0) && wrAcc && (wr_addr == rd_addr_a)) ? wd : regArr[rd_addr_a];
  assign alu_in_b = ((BYPASS != 0) && wrAcc && (wr_addr == rd_addr_b)) ? wd : regArr[rd_addr_b];
  assign out      = regArr[0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) regArr[i] <= '0;
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= 1'b0;
      case (state)
        IDLE: begin
          // A write in the same cycle as clr_req still lands; the clear
          // reaches that register later.
          if (wr_en) regArr[wr_addr] <= wd;
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          regArr[cnt] <= '0;
          wr_drop     <= wr_en;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_p.sv
module tb_reg_bank_p;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          res;
  logic [DW-1:0] in_a, in_b, cu_const, alu_out;
  logic [2:0]    src_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr, mov_addr, rd_addr_a, rd_addr_b;
  logic          clr_req;

  logic [DW-1:0] aA1, aB1, out1, aA0, aB0, out0;
  logic          busy1, drop1, busy0, drop0;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  reg_bank_p #(.DATA_W(DW), .DEPTH(16), .BYPASS(1)) dut (
    .clk(clk), .res(res), .in_a(in_a), .in_b(in_b), .cu_const(cu_const),
    .alu_out(alu_out), .src_sel(src_sel), .wr_en(wr_en), .wr_addr(wr_addr),
    .mov_addr(mov_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .clr_req(clr_req), .alu_in_a(aA1), .alu_in_b(aB1), .out(out1),
    .busy(busy1), .wr_drop(drop1));

  reg_bank_p #(.DATA_W(DW), .DEPTH(16), .BYPASS(0)) dutNb (
    .clk(clk), .res(res), .in_a(in_a), .in_b(in_b), .cu_const(cu_const),
    .alu_out(alu_out), .src_sel(src_sel), .wr_en(wr_en), .wr_addr(wr_addr),
    .mov_addr(mov_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .clr_req(clr_req), .alu_in_a(aA0), .alu_in_b(aB0), .out(out0),
    .busy(busy0), .wr_drop(drop0));

  typedef struct {
    logic [DW-1:0] ina, inb, cu, alu;
    logic [2:0]    sel;
    logic [AW-1:0] waddr, maddr, rda, rdb;
    logic [DW-1:0] expA, expB, expOut;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_sel = 3'd0; in_a = d; wr_addr = a; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  int k, busyCnt, dropCnt;

  initial begin
    // sources, move, self-move, move via sel 5
    vecs[0] = '{8'h11, 8'hE1, 8'hE2, 8'hE3, 3'd0, 4'd1, 4'd0, 4'd1, 4'd0, 8'h11, 8'h00, 8'h00};
    vecs[1] = '{8'hE0, 8'h22, 8'hE2, 8'hE3, 3'd1, 4'd2, 4'd0, 4'd1, 4'd2, 8'h11, 8'h22, 8'h00};
    vecs[2] = '{8'hE0, 8'hE1, 8'h33, 8'hE3, 3'd2, 4'd0, 4'd1, 4'd1, 4'd2, 8'h11, 8'h22, 8'h33};
    vecs[3] = '{8'hE0, 8'hE1, 8'hE2, 8'h44, 3'd3, 4'd3, 4'd0, 4'd3, 4'd0, 8'h44, 8'h33, 8'h33};
    vecs[4] = '{8'hA5, 8'hE1, 8'hE2, 8'hE3, 3'd0, 4'd5, 4'd0, 4'd5, 4'd3, 8'hA5, 8'h44, 8'h33};
    vecs[5] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 3'd4, 4'd0, 4'd5, 4'd5, 4'd0, 8'hA5, 8'hA5, 8'hA5};
    vecs[6] = '{8'h3C, 8'hE1, 8'hE2, 8'hE3, 3'd0, 4'd7, 4'd0, 4'd7, 4'd0, 8'h3C, 8'hA5, 8'hA5};
    vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd7, 4'd7, 4'd7, 4'd7, 4'd5, 8'h3C, 8'hA5, 8'hA5};
    vecs[8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 3'd5, 4'd6, 4'd3, 4'd6, 4'd3, 8'h44, 8'h44, 8'hA5};

    res = 1'b0; in_a = '0; in_b = '0; cu_const = '0; alu_out = '0; src_sel = '0;
    wr_en = 1'b0; wr_addr = '0; mov_addr = '0; rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 res = 1'b1;
    step();
    check("reset_busy", busy1, 0);
    check("reset_out", out1, 0);

    // ---- asynchronous reset mid-cycle ----
    writeReg(4'd0, 8'hFF);
    writeReg(4'd15, 8'hFF);
    rd_addr_a = 4'd15; rd_addr_b = 4'd0;
    #1;
    check("pre_reset_r15", aA1, 8'hFF);
    check("pre_reset_out", out1, 8'hFF);
    #2 res = 1'b0;
    #1;
    check("async_out", out1, 0);
    check("async_alu_a", aA1, 0);
    check("async_alu_b", aB1, 0);
    check("async_busy", busy1, 0);
    check("async_drop", drop1, 0);
    #1 res = 1'b1;
    step();
    check("r15_after_reset", aA1, 0);

    // ---- table-driven sources and moves ----
    for (int i = 0; i < 9; i++) begin
      in_a = vecs[i].ina; in_b = vecs[i].inb; cu_const = vecs[i].cu; alu_out = vecs[i].alu;
      src_sel = vecs[i].sel; wr_addr = vecs[i].waddr; mov_addr = vecs[i].maddr; wr_en = 1'b1;
      step();
      wr_en = 1'b0; rd_addr_a = vecs[i].rda; rd_addr_b = vecs[i].rdb;
      #1;
      check($sformatf("vec%0d_alu_a", i), aA1, vecs[i].expA);
      check($sformatf("vec%0d_alu_b", i), aB1, vecs[i].expB);
      check($sformatf("vec%0d_out", i), out1, vecs[i].expOut);
    end

    // ---- bypass vs. no bypass ----
    writeReg(4'd4, 8'h12);
    rd_addr_a = 4'd4; rd_addr_b = 4'd4;
    src_sel = 3'd2; cu_const = 8'h5A; wr_addr = 4'd4; wr_en = 1'b1;
    #1;
    check("bypass_a", aA1, 8'h5A);
    check("bypass_b", aB1, 8'h5A);
    check("bypass_out_unchanged", out1, 8'hA5);
    check("nobypass_a_old", aA0, 8'h12);
    step();
    wr_en = 1'b0;
    #1;
    check("nobypass_a_next", aA0, 8'h5A);

    // ---- clear sequence with same-cycle write, dropped write, second request ----
    for (int i = 0; i < 16; i++) writeReg(AW'(i), DW'(i + 1));
    src_sel = 3'd2; cu_const = 8'h77; wr_addr = 4'd0; wr_en = 1'b1; clr_req = 1'b1;
    step();
    k = 1; busyCnt = 0; dropCnt = 0;
    while (k <= 40) begin
      if (k == 3) begin
        wr_en = 1'b1; wr_addr = 4'd9; src_sel = 3'd0; in_a = 8'h99; clr_req = 1'b1; rd_addr_a = 4'd9;
      end else begin
        wr_en = 1'b0; clr_req = 1'b0;
      end
      if (k == 5) begin rd_addr_a = 4'd4; rd_addr_b = 4'd3; end
      #1;
      if (!busy1) break;
      busyCnt++;
      if (drop1) dropCnt++;
      if (k == 1) check("clr_same_cycle_write", out1, 8'h77);
      if (k == 2) check("clr_r0_zeroed", out1, 8'h00);
      if (k == 3) check("clr_no_bypass_r9", aA1, 8'h0A);
      if (k == 4) check("clr_wr_drop", drop1, 1);
      if (k == 5) begin
        check("clr_partial_r4", aA1, 8'h05);
        check("clr_partial_r3", aB1, 8'h00);
      end
      step();
      k++;
    end
    if (k > 40) check("clr_timeout", 1, 0);
    check("clr_busy_cycles", busyCnt, 16);
    check("clr_drop_count", dropCnt, 1);
    check("clr_drop_idle", drop1, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_b = AW'(i);
      #1;
      check($sformatf("clr_r%0d_zero", i), aB1, 0);
    end
    writeReg(4'd2, 8'h5C);
    rd_addr_a = 4'd2;
    #1;
    check("write_after_clear", aA1, 8'h5C);

    // ---- reset during a clear ----
    writeReg(4'd1, 8'h66);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (7) step();
    check("clr8_busy", busy1, 1);
    #1 res = 1'b0;
    #1;
    check("clr_abort_busy", busy1, 0);
    check("clr_abort_out", out1, 0);
    check("clr_abort_r2", aA1, 0);
    #1 res = 1'b1;
    step();
    check("clr_abort_idle", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/reg_bank_p.md
# reg_bank_p

Parametrised register bank for the APS datapath: `DEPTH` registers of `DATA_W` bits, with one write port and a five-way source mux (InA, InB, CU constant, ALU result, register-to-register move). It has two address-selectable ALU read ports with optional write-through bypass, and a fixed output tap on register 0. A multi-cycle clear sequencer zeroes the bank on request and reports busy while it runs. The block sits between the control unit and the ALU.

## Interface
Parameters:
- `DATA_W`, default 8: register and data-path width.
- `DEPTH`, default 16: number of registers; power of two, ≥ 4.
- `ADDR_W`, default $clog2(DEPTH): address width (derived).
- `BYPASS`, default 1: 1 forwards same-cycle write data to the read ports; 0 gives pure array reads.

Ports:
- `clk` input 1: single clock, rising edge.
- `res` input 1: reset, asynchronous, active-low.
- `in_a`, `in_b` input DATA_W: external data sources 0 and 1.
- `cu_const` input DATA_W: control-unit constant, source 2.
- `alu_out` input DATA_W: ALU result, source 3.
- `src_sel` input 3: write source select. 0 in_a, 1 in_b, 2 cu_const, 3 alu_out, 4–7 register move from `mov_addr`.
- `wr_en` input 1: write request.
- `wr_addr` input ADDR_W: destination register.
- `mov_addr` input ADDR_W: source register for a move.
- `rd_addr_a`, `rd_addr_b` input ADDR_W: read port addresses.
- `clr_req` input 1: start the clear sequence.
- `alu_in_a`, `alu_in_b` output DATA_W: read port data.
- `out` output DATA_W: register 0 contents.
- `busy` output 1: clear sequence in progress.
- `wr_drop` output 1: one-cycle pulse flagging a write rejected during a clear.

## Operation
- **Write datapath**
  - Write data `wd` is combinational from `src_sel`.
  - For moves, `wd` = the current array value of register `mov_addr`, before any update in this cycle. A move with `mov_addr == wr_addr` leaves the register unchanged.
  - A write is accepted when `wr_en` = 1 and state = IDLE. At the rising edge, `reg[wr_addr] <= wd`.
- **Read ports** (combinational)
  - `alu_in_x = reg[rd_addr_x]`.
  - If `BYPASS` = 1 and an accepted write targets `rd_addr_x` in the same cycle, `alu_in_x = wd`.
- **Register 0 tap:** `out = reg[0]`, array value only, never bypassed.
- **FSM, two states**
  - IDLE:
    - `clr_req` = 1 → CLEAR, with `cnt` <= 0.
    - A write asserted in the same cycle as `clr_req` is still accepted.
  - CLEAR, each cycle:
    - `reg[cnt] <= 0` and `cnt <= cnt+1`.
    - When `cnt == DEPTH-1`: clear that register, then → IDLE.
    - `clr_req` is ignored.
    - `wr_en` = 1 writes nothing, and `wr_drop` pulses the next cycle.
- **Outputs by state**
  - `busy` = 1 exactly while state = CLEAR. It is registered from the state.
  - Reads during CLEAR return the partially cleared array. Bypass is inactive because no writes are accepted.
- **Reset** (`res` = 0): immediate and asynchronous.
  - All DEPTH registers → 0, including the highest index.
  - State → IDLE, `cnt` → 0, `busy` → 0, `wr_drop` → 0.
  - `out`, `alu_in_a`, `alu_in_b` therefore → 0, provided no bypass is active.
  - Reset during CLEAR aborts the sequence; the bank is zero anyway.

## Timing
- Write latency: 1 cycle. Data is visible on `out` and on non-bypassed reads the cycle after the edge. With `BYPASS` = 1 it is visible on reads in the same cycle, combinationally.
- Clear:
  - `clr_req` is sampled at edge N, and `busy` = 1 from N.
  - Register k is zeroed at edge N+1+k.
  - `busy` falls after edge N+DEPTH, so it is high for DEPTH cycles.
  - A write is accepted again in the first cycle with `busy` = 0.
- `wr_drop`: high for one cycle after each edge at which a write was rejected. Back-to-back rejections hold it high.
- Critical path: `src_sel`/`mov_addr` read mux → `wd` → bypass mux → `alu_in_x`.

## Test plan
- **Reset:** drive `res` = 0 mid-cycle after writing 0xFF to reg 15 → all outputs 0 immediately. Reading reg 15 after release gives 0x00.
- **Sources:** write `in_a`=0x11 to r1, `in_b`=0x22 to r2, `cu_const`=0x33 to r0, `alu_out`=0x44 to r3 → `out`=0x33, `alu_in_a`(r1)=0x11, `alu_in_b`(r2)=0x22, r3 readback 0x44.
- **Move:** r5=0xA5, then move r5→r0 (`src_sel`=4) → `out`=0xA5 next cycle, r5 unchanged. Move r7→r7 leaves r7 unchanged.
- **Bypass:**
  - `BYPASS`=1, `rd_addr_a`=4, write `cu_const`=0x5A to r4 → `alu_in_a`=0x5A in the write cycle. `out` does not change.
  - `BYPASS`=0, same stimulus → old r4 value shown until the next cycle.
- **Clear:** fill r0–r15 with nonzero values and pulse `clr_req` together with a write of 0x77 to r0 → r0 shows 0x77 for one cycle, then is zeroed. `busy` stays high exactly 16 cycles and all registers end at 0.
- **Write during clear:** `wr_en` with 0x99 to r9 at cycle 3 of the clear → `wr_drop` pulses once, r9 ends 0. A second `clr_req` during the clear does not extend `busy`. Asserting `res` at cycle 8 of the clear sets `busy` to 0 at once.
